// File: rtl/host_link_pkg.sv
// Shared definitions for the host link: arbiter states, requester lane
// numbering and the host-side stall limit.
package host_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_t;

    localparam int REQ_PROTOCOL = 0;
    localparam int REQ_MEAS     = 1;
    localparam int REQ_STATUS   = 2;

    // Also the protocol FSM's max-wait, so both give up on the host together.
    localparam int HOST_TIMEOUT_CYCLES = 2500000;

    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/tx_fifo_arbiter_if.sv
// Requester byte lanes plus the host write-FIFO port of the arbiter.
// Lane i handshake: a byte moves on every cycle where req_valid[i] and
// req_ready[i] are both high; req_valid may drop at any time, req_ready is
// combinational and only ever high for the granted lane.
interface tx_fifo_arbiter_if #(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               wr_full;
    logic               wr_en;
    logic [7:0]         wr_data;
    logic [N_REQ-1:0]   grant;
    logic               busy;
    logic [N_REQ-1:0]   abort;

    modport master (
        input  req_valid, req_data, req_last, wr_full,
        output req_ready, wr_en, wr_data, grant, busy, abort
    );

    modport slave (
        output req_valid, req_data, req_last, wr_full,
        input  req_ready, wr_en, wr_data, grant, busy, abort
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping around, reported both as one-hot and as an index.
module rr_pick
    import host_link_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!o_valid && i_req[wrap_idx(int'(i_ptr), i, N_REQ)]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(wrap_idx(int'(i_ptr), i, N_REQ));
                o_onehot[wrap_idx(int'(i_ptr), i, N_REQ)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_fifo_arbiter.sv
// Packet-locked round-robin arbiter sharing the host write FIFO between
// byte-stream requesters, with a per-packet stall timeout.
module tx_fifo_arbiter
    import host_link_pkg::*;
#(
    parameter int N_REQ          = 3,
    parameter int TIMEOUT_CYCLES = HOST_TIMEOUT_CYCLES,
    parameter int TIMEOUT_W      = 24
) (
    input  logic              clk,
    input  logic              reset,
    tx_fifo_arbiter_if.master bus,
    output arb_state_t        o_state
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [TIMEOUT_W-1:0] STALL_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] STALL_MAX  = '1;

    arb_state_t           r_state;
    arb_state_t           w_next_state;
    logic [N_REQ-1:0]     r_grant;
    logic [N_REQ-1:0]     r_abort;
    logic [IDX_W-1:0]     r_owner;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic                 r_busy;
    logic                 r_wr_en;
    logic [7:0]           r_wr_data;
    logic [TIMEOUT_W-1:0] r_stall;

    logic [N_REQ-1:0]     w_pick_onehot;
    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_pick_valid;
    logic [IDX_W-1:0]     w_next_ptr;
    logic [7:0]           w_owner_data;
    logic                 w_owner_last;
    logic                 w_accept;
    logic                 w_stall_hit;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req    (bus.req_valid),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    assign w_owner_data = bus.req_data[8*int'(r_owner) +: 8];
    assign w_owner_last = bus.req_last[r_owner];
    assign w_next_ptr   = IDX_W'(wrap_idx(int'(r_owner), 1, N_REQ));

    // !r_wr_en gives the FIFO one cycle to reflect the previous write in wr_full.
    assign w_accept    = (r_state == ST_XFER) && bus.req_valid[r_owner]
                         && !bus.wr_full && !r_wr_en;
    assign w_stall_hit = (r_state == ST_XFER) && !w_accept && (r_stall == STALL_LAST);

    assign bus.req_ready = w_accept ? r_grant : '0;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_data   = r_wr_data;
    assign bus.grant     = r_grant;
    assign bus.busy      = r_busy;
    assign bus.abort     = r_abort;
    assign o_state       = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_pick_valid) w_next_state = ST_XFER;
            ST_XFER: begin
                if (w_accept && w_owner_last) w_next_state = ST_IDLE;
                else if (w_stall_hit)         w_next_state = ST_ABORT;
            end
            ST_ABORT: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant   <= '0;
            r_abort   <= '0;
            r_owner   <= '0;
            r_rr_ptr  <= '0;
            r_busy    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_data <= 8'h00;
            r_stall   <= '0;
        end else begin
            r_wr_en <= w_accept;
            r_abort <= '0;
            if (w_accept) r_wr_data <= w_owner_data;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick_onehot;
                        r_owner <= w_pick_idx;
                        r_busy  <= 1'b1;
                        r_stall <= '0;
                    end
                end
                ST_XFER: begin
                    if (w_accept) begin
                        r_stall <= '0;
                        if (w_owner_last) begin
                            r_grant  <= '0;
                            r_busy   <= 1'b0;
                            r_rr_ptr <= w_next_ptr;
                        end
                    end else begin
                        if (r_stall != STALL_MAX) r_stall <= r_stall + 1'b1;
                        if (w_stall_hit)          r_abort <= r_grant;
                    end
                end
                ST_ABORT: begin
                    r_grant  <= '0;
                    r_busy   <= 1'b0;
                    r_rr_ptr <= w_next_ptr;
                    r_stall  <= '0;
                end
                default: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// Bench for tx_fifo_arbiter: lane drivers fed from per-lane byte queues, a
// write-port scoreboard, table-driven arbitration rounds and corner sequences.
module tb_tx_fifo_arbiter;
    import host_link_pkg::*;

    localparam int N = 3;
    localparam int T = 16;

    typedef struct packed {
        logic [2:0] mask;  // lanes offering a single-byte packet
        logic [1:0] n;     // number of grants expected
        logic [5:0] ord;   // expected grant order, first in [1:0]
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    arb_state_t  dbg_state;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic [7:0]   exp_q[$];
    logic [8:0]   lane_q[N][$];
    int unsigned  wr_cyc_q[$];
    logic [N-1:0] drv_seen;
    vec_t         vecs[9];

    tx_fifo_arbiter_if #(.N_REQ(N)) bus ();

    tx_fifo_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (T),
        .TIMEOUT_W      (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .o_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] vbyte(input int v, input int i);
        return 8'((v << 4) | (i + 1));
    endfunction

    function automatic bit lanes_empty();
        for (int i = 0; i < N; i++) if (lane_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic flush_all();
        for (int i = 0; i < N; i++) lane_q[i].delete();
        exp_q.delete();
    endtask

    // Lane drivers: present the queue head, retire it once it was accepted.
    initial begin
        drv_seen      = '0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (drv_seen[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
            for (int i = 0; i < N; i++) begin
                if (lane_q[i].size() > 0) begin
                    bus.req_valid[i]         = 1'b1;
                    bus.req_data[8*i +: 8]   = lane_q[i][0][7:0];
                    bus.req_last[i]          = lane_q[i][0][8];
                end else begin
                    bus.req_valid[i]         = 1'b0;
                    bus.req_data[8*i +: 8]   = 8'h00;
                    bus.req_last[i]          = 1'b0;
                end
            end
            #1 drv_seen = bus.req_valid & bus.req_ready;
        end
    end

    // Write-port scoreboard.
    initial begin
        logic       prev_en;
        logic [7:0] exp_b;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.wr_en) begin
                check("wr_en_back_to_back", prev_en, 1'b0);
                wr_cyc_q.push_back(cyc);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_write: got %0h expected none", bus.wr_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    n_checks--;
                    check("wr_data", bus.wr_data, exp_b);
                end
            end
            prev_en = bus.wr_en;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_idle(input string name, input int budget);
        logic done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk); #2;
            if (!bus.busy && !bus.wr_en && exp_q.size() == 0 && lanes_empty()) done = 1'b1;
        end
        check(name, done, 1'b1);
    endtask

    task automatic wait_grant(input string name, input logic [N-1:0] exp_g, input int budget);
        logic got;
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk); #2;
            if (bus.grant != '0) begin
                check(name, bus.grant, exp_g);
                got = 1'b1;
            end
        end
        check({name, "_seen"}, got, 1'b1);
    endtask

    task automatic run_vector(input int v);
        vec_t         vr;
        logic [N-1:0] prev_g, g;
        int           k, run;
        logic         done;
        vr = vecs[v]; prev_g = '0; k = 0; run = 0; done = 1'b0;
        for (int j = 0; j < int'(vr.n); j++) exp_q.push_back(vbyte(v, int'(vr.ord[2*j +: 2])));
        for (int i = 0; i < N; i++) if (vr.mask[i]) lane_q[i].push_back({1'b1, vbyte(v, i)});
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk); #2;
            g = bus.grant;
            if (g != '0 && prev_g == '0) begin
                if (k < int'(vr.n))
                    check($sformatf("vec%0d_grant%0d", v, k), g, 32'(1 << vr.ord[2*k +: 2]));
                else
                    check($sformatf("vec%0d_extra_grant", v), g, 0);
                k++;
                run = 1;
            end else if (g != '0) begin
                run++;
            end
            if (g == '0 && prev_g != '0) check($sformatf("vec%0d_grant_len", v), run, 1);
            if (k >= int'(vr.n) && g == '0 && !bus.busy && exp_q.size() == 0) done = 1'b1;
            prev_g = g;
        end
        check($sformatf("vec%0d_done", v), done, 1'b1);
    endtask

    initial begin
        int unsigned p_cyc, acc_cyc;
        int          bad, wr_cnt;
        logic        got, seen33, gbad, preempt;

        vecs[0] = '{mask: 3'b111, n: 2'd3, ord: {2'd2, 2'd1, 2'd0}};
        vecs[1] = '{mask: 3'b110, n: 2'd2, ord: {2'd0, 2'd2, 2'd1}};
        vecs[2] = '{mask: 3'b100, n: 2'd1, ord: {2'd0, 2'd0, 2'd2}};
        vecs[3] = '{mask: 3'b101, n: 2'd2, ord: {2'd0, 2'd2, 2'd0}};
        vecs[4] = '{mask: 3'b010, n: 2'd1, ord: {2'd0, 2'd0, 2'd1}};
        vecs[5] = '{mask: 3'b011, n: 2'd2, ord: {2'd0, 2'd1, 2'd0}};
        vecs[6] = '{mask: 3'b111, n: 2'd3, ord: {2'd1, 2'd0, 2'd2}};
        vecs[7] = '{mask: 3'b001, n: 2'd1, ord: {2'd0, 2'd0, 2'd0}};
        vecs[8] = '{mask: 3'b101, n: 2'd2, ord: {2'd0, 2'd0, 2'd2}};

        reset       = 1'b1;
        bus.wr_full = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_wr_en",     bus.wr_en,     1'b0);
        check("rst_wr_data",   bus.wr_data,   8'h00);
        check("rst_grant",     bus.grant,     3'b000);
        check("rst_busy",      bus.busy,      1'b0);
        check("rst_abort",     bus.abort,     3'b000);
        check("rst_req_ready", bus.req_ready, 3'b000);
        check("rst_state",     dbg_state,     ST_IDLE);
        @(negedge clk) reset = 1'b0;
        @(negedge clk); #2;
        check("post_rst_state", dbg_state, ST_IDLE);
        check("post_rst_grant", bus.grant, 3'b000);

        // Arbitration rounds of single-byte packets; rr_ptr carries between rows.
        for (int v = 0; v < 9; v++) run_vector(v);

        // Single source: three bytes on lane 1.
        wr_cyc_q.delete();
        p_cyc = cyc;
        lane_q[REQ_MEAS].push_back({1'b0, 8'h11});
        lane_q[REQ_MEAS].push_back({1'b0, 8'h22});
        lane_q[REQ_MEAS].push_back({1'b1, 8'h33});
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        seen33 = 1'b0; gbad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #2;
            if (bus.busy && bus.grant != 3'b010) gbad = 1'b1;
            if (bus.wr_en && bus.wr_data == 8'h33) begin
                check("single_grant_clear", bus.grant, 3'b000);
                seen33 = 1'b1;
            end
            if (seen33 && !bus.busy && exp_q.size() == 0) break;
        end
        check("single_last_seen", seen33, 1'b1);
        check("single_grant_held", gbad, 1'b0);
        check("single_wr_count", wr_cyc_q.size(), 3);
        if (wr_cyc_q.size() == 3) begin
            check("single_first_latency", wr_cyc_q[0] - p_cyc, 3);
            check("single_gap01", wr_cyc_q[1] - wr_cyc_q[0], 2);
            check("single_gap12", wr_cyc_q[2] - wr_cyc_q[1], 2);
        end

        // Contention from reset: lane 0 and lane 2, two packets each.
        @(negedge clk) reset = 1'b1;
        flush_all();
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
            lane_q[REQ_PROTOCOL].push_back({j[0], 8'(8'hA0 + j)});
            lane_q[REQ_STATUS].push_back({j[0], 8'(8'hC0 + j)});
        end
        exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
        exp_q.push_back(8'hC0); exp_q.push_back(8'hC1);
        exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
        exp_q.push_back(8'hC2); exp_q.push_back(8'hC3);
        wait_grant("contention_first_grant", 3'b001, 10);
        wait_idle("contention_done", 80);

        // Backpressure: FIFO full for 10 cycles in the middle of a packet.
        for (int j = 0; j < 4; j++) begin
            lane_q[REQ_PROTOCOL].push_back({(j == 3), 8'(8'hB0 + j)});
            exp_q.push_back(8'(8'hB0 + j));
        end
        wr_cnt = 0; got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (bus.wr_en) wr_cnt++;
            if (wr_cnt == 2) got = 1'b1;
        end
        check("bp_reached", got, 1'b1);
        bus.wr_full = 1'b1;
        bad = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk); #2;
            if (bus.wr_en || bus.req_ready != '0) bad++;
        end
        @(negedge clk);
        if (bus.wr_en) bad++;
        check("bp_quiet", bad, 0);
        bus.wr_full = 1'b0;
        #2;
        check("bp_resume_ready", bus.req_ready, 3'b001);
        @(negedge clk); #2;
        check("bp_resume_wr", bus.wr_en, 1'b1);
        wait_idle("bp_done", 40);

        // Timeout: lane 0 sends one non-last byte then goes quiet.
        lane_q[REQ_PROTOCOL].push_back({1'b0, 8'hA5});
        exp_q.push_back(8'hA5);
        got = 1'b0; acc_cyc = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk); #2;
            if (bus.req_ready[0]) begin
                acc_cyc = cyc;
                got = 1'b1;
            end
        end
        check("to_accept_seen", got, 1'b1);
        lane_q[REQ_MEAS].push_back({1'b1, 8'h5A});
        exp_q.push_back(8'h5A);
        got = 1'b0; preempt = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk); #2;
            if (bus.req_ready[1]) preempt = 1'b1;
            if (bus.abort != '0) begin
                check("to_abort_delay", cyc - acc_cyc, T + 1);
                check("to_abort_lane", bus.abort, 3'b001);
                got = 1'b1;
            end
        end
        check("to_abort_seen", got, 1'b1);
        check("to_no_preempt", preempt, 1'b0);
        @(negedge clk); #2;
        check("to_abort_pulse", bus.abort, 3'b000);
        wait_grant("to_next_grant", 3'b010, 10);
        wait_idle("to_done", 40);

        // Reset in the middle of a lane-2 packet.
        for (int j = 0; j < 3; j++) begin
            lane_q[REQ_STATUS].push_back({(j == 2), 8'(8'hD0 + j)});
            exp_q.push_back(8'(8'hD0 + j));
        end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.wr_en) got = 1'b1;
        end
        check("rstmid_in_xfer", got, 1'b1);
        @(posedge clk); #2;
        reset = 1'b1;
        flush_all();
        #1;
        check("rstmid_wr_en", bus.wr_en, 1'b0);
        check("rstmid_grant", bus.grant, 3'b000);
        check("rstmid_busy",  bus.busy,  1'b0);
        check("rstmid_state", dbg_state, ST_IDLE);
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        lane_q[REQ_STATUS].push_back({1'b1, 8'hE2});
        lane_q[REQ_PROTOCOL].push_back({1'b1, 8'hE0});
        exp_q.push_back(8'hE0); exp_q.push_back(8'hE2);
        wait_grant("rstmid_first_grant", 3'b001, 10);
        wait_idle("rstmid_done", 40);

        check("final_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
